// File: rtl/calc_delta_pkg.sv
// Shared angle-width defaults and FSM state encoding for the shortest-path
// angle delta calculator.
package calc_delta_pkg;

  localparam int ANGLE_W_DEF = 12;

  function automatic int half_turn(input int w);
    return 1 << (w - 1);
  endfunction

  localparam int HALF_TURN = half_turn(ANGLE_W_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_DIFF,
    ST_SELECT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/calc_delta.sv
// Shortest rotational path (magnitude + direction) between current and target
// wheel angle on a 2**ANGLE_W count circle, computed over a four-state pipeline.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | outputs held 0, waiting for enable_calc
// LATCH  | capture target_angle / current_angle
// DIFF   | forward (increasing) distance, modulo one revolution
// SELECT | choose shorter direction, load outputs, raise pulse
// DONE   | outputs valid, calc_updated high for this cycle only
module calc_delta
  import calc_delta_pkg::*;
#(
  parameter int ANGLE_W = ANGLE_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable_calc,
  input  logic [ANGLE_W-1:0] target_angle,
  input  logic [ANGLE_W-1:0] current_angle,
  output logic               dir_shortest,
  output logic [ANGLE_W-1:0] delta_angle,
  output logic               calc_updated
);

  localparam logic [ANGLE_W-1:0] HALF = ANGLE_W'(half_turn(ANGLE_W));

  state_t             state_q, state_nxt;
  logic [ANGLE_W-1:0] tgt_q, tgt_nxt;
  logic [ANGLE_W-1:0] cur_q, cur_nxt;
  logic [ANGLE_W-1:0] fwd_q, fwd_nxt;
  logic               dir_q, dir_nxt;
  logic [ANGLE_W-1:0] dlt_q, dlt_nxt;
  logic               upd_q, upd_nxt;
  logic               dir_n;
  logic [ANGLE_W-1:0] dlt_n;

  // Half-turn tie resolves toward the increasing direction.
  always_comb begin
    dir_n = 1'b0;
    dlt_n = '0;
    if (fwd_q <= HALF) begin
      dir_n = 1'b1;
      dlt_n = fwd_q;
    end else begin
      dir_n = 1'b0;
      dlt_n = '0 - fwd_q;
    end
  end

  always_comb begin
    state_nxt = state_q;
    tgt_nxt   = tgt_q;
    cur_nxt   = cur_q;
    fwd_nxt   = fwd_q;
    dir_nxt   = dir_q;
    dlt_nxt   = dlt_q;
    upd_nxt   = 1'b0;
    if (!enable_calc) begin
      state_nxt = ST_IDLE;
      dir_nxt   = 1'b0;
      dlt_nxt   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          dir_nxt   = 1'b0;
          dlt_nxt   = '0;
          state_nxt = ST_LATCH;
        end
        ST_LATCH: begin
          tgt_nxt   = target_angle;
          cur_nxt   = current_angle;
          state_nxt = ST_DIFF;
        end
        ST_DIFF: begin
          fwd_nxt   = tgt_q - cur_q;
          state_nxt = ST_SELECT;
        end
        // Outputs load on the edge into DONE so they are valid during DONE.
        ST_SELECT: begin
          dir_nxt   = dir_n;
          dlt_nxt   = dlt_n;
          upd_nxt   = 1'b1;
          state_nxt = ST_DONE;
        end
        ST_DONE: begin
          state_nxt = ST_LATCH;
        end
        default: begin
          state_nxt = ST_IDLE;
          dir_nxt   = 1'b0;
          dlt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      cur_q   <= '0;
      fwd_q   <= '0;
      dir_q   <= 1'b0;
      dlt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      tgt_q   <= tgt_nxt;
      cur_q   <= cur_nxt;
      fwd_q   <= fwd_nxt;
      dir_q   <= dir_nxt;
      dlt_q   <= dlt_nxt;
      upd_q   <= upd_nxt;
    end
  end

  assign dir_shortest = dir_q;
  assign delta_angle  = dlt_q;
  assign calc_updated = upd_q;

endmodule

// File: tb/tb_calc_delta.sv
// Self-checking bench for calc_delta: directed corner cases, randomized
// vectors, abort, continuous recompute and async reset, against an arithmetic model.
module tb_calc_delta;

  logic        clock;
  logic        reset_n;
  logic        enable_calc;
  logic [11:0] target_angle;
  logic [11:0] current_angle;
  logic        dir_shortest;
  logic [11:0] delta_angle;
  logic        calc_updated;

  int n_vec;
  int n_err;

  calc_delta dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable_calc   (enable_calc),
    .target_angle  (target_angle),
    .current_angle (current_angle),
    .dir_shortest  (dir_shortest),
    .delta_angle   (delta_angle),
    .calc_updated  (calc_updated)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: walk forward around the circle; shorter way wins, ties go forward.
  function automatic void model(input int t, input int c, output int d, output bit dr);
    int fwd;
    fwd = ((t - c) % 4096 + 4096) % 4096;
    if (fwd <= 2048) begin
      dr = 1'b1;
      d  = fwd;
    end else begin
      dr = 1'b0;
      d  = 4096 - fwd;
    end
  endfunction

  task automatic test_reset();
    reset_n       = 1'b0;
    enable_calc   = 1'b0;
    target_angle  = 12'd0;
    current_angle = 12'd0;
    #4;
    n_vec++;
    if (calc_updated !== 1'b0 || dir_shortest !== 1'b0 || delta_angle !== 12'd0) begin
      n_err++;
      $display("FAIL reset_vals: upd=%b dir=%b dlt=%0d, required 0/0/0",
               calc_updated, dir_shortest, delta_angle);
    end
    #1 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (calc_updated !== 1'b0 || dir_shortest !== 1'b0 || delta_angle !== 12'd0) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: upd=%b dir=%b dlt=%0d, required 0/0/0",
                 i, calc_updated, dir_shortest, delta_angle);
      end
    end
  endtask

  // One calculation from IDLE; inputs scrambled once they have been latched.
  task automatic test_single(input string name, input int t, input int c);
    int exp_d;
    bit exp_dir;
    model(t, c, exp_d, exp_dir);
    target_angle  = 12'(t);
    current_angle = 12'(c);
    enable_calc   = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 2) begin
        target_angle  = 12'($urandom);
        current_angle = 12'($urandom);
      end
      n_vec++;
      if (calc_updated !== (k == 4)) begin
        n_err++;
        $display("FAIL %s pulse edge%0d: upd=%b, required %b", name, k, calc_updated, k == 4);
      end
    end
    n_vec++;
    if (delta_angle !== 12'(exp_d) || dir_shortest !== exp_dir) begin
      n_err++;
      $display("FAIL %s result: dlt=%0d dir=%b, required dlt=%0d dir=%b",
               name, delta_angle, dir_shortest, exp_d, exp_dir);
    end
    enable_calc = 1'b0;
    tick();
    n_vec++;
    if (calc_updated !== 1'b0 || dir_shortest !== 1'b0 || delta_angle !== 12'd0) begin
      n_err++;
      $display("FAIL %s disable_clear: upd=%b dir=%b dlt=%0d, required 0/0/0",
               name, calc_updated, dir_shortest, delta_angle);
    end
  endtask

  task automatic test_directed();
    test_single("fwd_924",   1024, 100);
    test_single("rev_924",   100,  1024);
    test_single("wrap_fwd",  200,  3600);
    test_single("wrap_rev",  3600, 200);
    test_single("tie_half",  2148, 100);
    test_single("equal",     500,  500);
    test_single("tie_wrap",  0,    2048);
    test_single("just_over", 0,    2047);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      test_single("random", int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
  endtask

  // Abort in DIFF after a completed result: outputs hold, then clear, no pulse.
  task automatic test_abort();
    int exp_d;
    bit exp_dir;
    model(3000, 10, exp_d, exp_dir);
    target_angle  = 12'd3000;
    current_angle = 12'd10;
    enable_calc   = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (calc_updated !== 1'b0 || delta_angle !== 12'(exp_d) || dir_shortest !== exp_dir) begin
        n_err++;
        $display("FAIL abort_hold cyc%0d: upd=%b dlt=%0d dir=%b, required 0/%0d/%b",
                 k, calc_updated, delta_angle, dir_shortest, exp_d, exp_dir);
      end
    end
    enable_calc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (calc_updated !== 1'b0 || dir_shortest !== 1'b0 || delta_angle !== 12'd0) begin
        n_err++;
        $display("FAIL abort_clear cyc%0d: upd=%b dir=%b dlt=%0d, required 0/0/0",
                 k, calc_updated, dir_shortest, delta_angle);
      end
    end
  endtask

  // Continuous mode: pulse every 4 cycles, values stable between pulses.
  task automatic test_back_to_back();
    int exp_d;
    bit exp_dir;
    int t, c;
    t = int'($urandom_range(1, 4095));
    c = int'($urandom_range(0, 4095));
    model(t, c, exp_d, exp_dir);
    target_angle  = 12'(t);
    current_angle = 12'(c);
    enable_calc   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_vec++;
      if (calc_updated !== (k % 4 == 0)) begin
        n_err++;
        $display("FAIL b2b pulse cyc%0d: upd=%b, required %b", k, calc_updated, k % 4 == 0);
      end
      if (k >= 4) begin
        n_vec++;
        if (delta_angle !== 12'(exp_d) || dir_shortest !== exp_dir) begin
          n_err++;
          $display("FAIL b2b value cyc%0d: dlt=%0d dir=%b, required %0d/%b",
                   k, delta_angle, dir_shortest, exp_d, exp_dir);
        end
      end
    end
    enable_calc = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    target_angle  = 12'd1024;
    current_angle = 12'd100;
    enable_calc   = 1'b1;
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (calc_updated !== 1'b0 || dir_shortest !== 1'b0 || delta_angle !== 12'd0) begin
      n_err++;
      $display("FAIL async_reset: upd=%b dir=%b dlt=%0d, required 0/0/0",
               calc_updated, dir_shortest, delta_angle);
    end
    enable_calc = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    test_single("post_reset", 1024, 100);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
